// File: rtl/tdm_demux_pkg.sv
// Shared constants and state encoding for the 4-slot TDM receive demultiplexer.
package tdm_demux_pkg;
  localparam int NUM_LANES = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;
endpackage

// File: rtl/tdm_demux4_decoder.sv
// 2-to-4 one-hot decoder with enable; selects which lane a beat is written into.
module demux_decoder
  import tdm_demux_pkg::*;
(
  input  logic                 address0,
  input  logic                 address1,
  input  logic                 en,
  output logic [NUM_LANES-1:0] sel
);
  logic [SLOT_W-1:0] address;

  assign address = {address1, address0};

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_sel
    assign sel[gi] = en && (address == SLOT_W'(gi));
  end
endmodule

// File: rtl/tdm_demux4.sv
// Splits a 4-slot TDM stream (sync on slot 0) into four lane registers that are
// published together with a one-cycle frame_valid pulse once a frame is complete.
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic                 sync_in,
  input  logic [WIDTH-1:0]     data_in,
  output logic [WIDTH-1:0]     out0,
  output logic [WIDTH-1:0]     out1,
  output logic [WIDTH-1:0]     out2,
  output logic [WIDTH-1:0]     out3,
  output logic                 frame_valid,
  output logic [NUM_LANES-1:0] lane_strobe,
  output logic                 locked,
  output logic                 sync_err
);
  state_t               state_reg;
  logic [SLOT_W-1:0]    slot_reg;
  // Lane 3 never needs holding: its beat goes straight into out3 with the frame.
  logic [WIDTH-1:0]     stage_reg [NUM_LANES-1];
  logic [WIDTH-1:0]     out_reg   [NUM_LANES];
  logic                 frame_valid_reg;
  logic                 sync_err_reg;
  logic [NUM_LANES-1:0] lane_strobe_reg;

  logic [SLOT_W-1:0]    wr_addr;
  logic                 wr_en;
  logic [NUM_LANES-1:0] wr_sel;

  // Any sync beat restarts at slot 0; a sync-less beat at slot 0 is a violation and is dropped.
  always_comb begin
    wr_addr = sync_in ? '0 : slot_reg;
    wr_en   = 1'b0;
    if (valid_in) begin
      if (state_reg == HUNT) wr_en = sync_in;
      else                   wr_en = sync_in || (slot_reg != '0);
    end
  end

  demux_decoder u_decoder (
    .address0 (wr_addr[0]),
    .address1 (wr_addr[1]),
    .en       (wr_en),
    .sel      (wr_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= HUNT;
      slot_reg        <= '0;
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
      lane_strobe_reg <= '0;
      for (int i = 0; i < NUM_LANES - 1; i++) stage_reg[i] <= '0;
      for (int i = 0; i < NUM_LANES; i++)     out_reg[i]   <= '0;
    end else begin
      frame_valid_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
      lane_strobe_reg <= wr_sel;

      for (int i = 0; i < NUM_LANES - 1; i++) begin
        if (wr_sel[i]) stage_reg[i] <= data_in;
      end

      if (wr_sel[NUM_LANES-1]) begin
        for (int i = 0; i < NUM_LANES - 1; i++) out_reg[i] <= stage_reg[i];
        out_reg[NUM_LANES-1] <= data_in;
        frame_valid_reg      <= 1'b1;
      end

      if (valid_in) begin
        case (state_reg)
          HUNT: begin
            if (sync_in) begin
              state_reg <= LOCKED;
              slot_reg  <= SLOT_W'(1);
            end
          end
          LOCKED: begin
            if (sync_in) begin
              sync_err_reg <= (slot_reg != '0);
              slot_reg     <= SLOT_W'(1);
            end else if (slot_reg == '0) begin
              sync_err_reg <= 1'b1;
              state_reg    <= HUNT;
            end else begin
              slot_reg <= slot_reg + SLOT_W'(1);
            end
          end
          default: begin
            state_reg <= HUNT;
            slot_reg  <= '0;
          end
        endcase
      end
    end
  end

  assign out0        = out_reg[0];
  assign out1        = out_reg[1];
  assign out2        = out_reg[2];
  assign out3        = out_reg[3];
  assign frame_valid = frame_valid_reg;
  assign sync_err    = sync_err_reg;
  assign lane_strobe = lane_strobe_reg;
  assign locked      = (state_reg == LOCKED);
endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: a frame-assembly model predicts each cycle's outputs,
// a separate monitor pops and compares them one cycle after every driven beat.
module tb_tdm_demux4;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic       sync_in;
  logic [7:0] data_in;
  logic [7:0] out0, out1, out2, out3;
  logic       frame_valid;
  logic [3:0] lane_strobe;
  logic       locked;
  logic       sync_err;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .sync_in     (sync_in),
    .data_in     (data_in),
    .out0        (out0),
    .out1        (out1),
    .out2        (out2),
    .out3        (out3),
    .frame_valid (frame_valid),
    .lane_strobe (lane_strobe),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      strobe;
    logic            lk;
    logic            fv;
    logic            err;
    logic [3:0][7:0] outs;
  } exp_t;

  exp_t       exp_q [$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_frames = 0;

  // Reference model: lane contents are simply the bytes collected since the last slot 0.
  logic       m_locked;
  logic [7:0] m_part [$];
  logic [7:0] m_outs [4];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_part.delete();
    for (int k = 0; k < 4; k++) m_outs[k] = 8'h00;
  endtask

  task automatic beat(input logic v, input logic s, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    valid_in = v;
    sync_in  = s;
    data_in  = d;
    e.strobe = 4'b0000;
    e.fv     = 1'b0;
    e.err    = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_part.delete();
          m_part.push_back(d);
          m_locked = 1'b1;
          e.strobe = 4'b0001;
        end
      end else if (s) begin
        e.err = (m_part.size() != 0);
        m_part.delete();
        m_part.push_back(d);
        e.strobe = 4'b0001;
      end else if (m_part.size() == 0) begin
        e.err    = 1'b1;
        m_locked = 1'b0;
      end else begin
        e.strobe = 4'(1 << m_part.size());
        m_part.push_back(d);
        if (m_part.size() == 4) begin
          for (int k = 0; k < 4; k++) m_outs[k] = m_part[k];
          e.fv = 1'b1;
          m_part.delete();
        end
      end
    end
    e.lk = m_locked;
    for (int k = 0; k < 4; k++) e.outs[k] = m_outs[k];
    exp_q.push_back(e);
  endtask

  task automatic frame(input logic [7:0] a, b, c, d);
    beat(1'b1, 1'b1, a);
    beat(1'b1, 1'b0, b);
    beat(1'b1, 1'b0, c);
    beat(1'b1, 1'b0, d);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out0"}, 32'(out0), 32'h0);
    chk({tag, "_out1"}, 32'(out1), 32'h0);
    chk({tag, "_out2"}, 32'(out2), 32'h0);
    chk({tag, "_out3"}, 32'(out3), 32'h0);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 32'h0);
    chk({tag, "_lane_strobe"}, 32'(lane_strobe), 32'h0);
    chk({tag, "_locked"}, 32'(locked), 32'h0);
    chk({tag, "_sync_err"}, 32'(sync_err), 32'h0);
  endtask

  // Monitor: one expectation per driven cycle, compared just after the clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("lane_strobe", 32'(lane_strobe), 32'(e.strobe));
        chk("locked", 32'(locked), 32'(e.lk));
        chk("frame_valid", 32'(frame_valid), 32'(e.fv));
        chk("sync_err", 32'(sync_err), 32'(e.err));
        chk("out0", 32'(out0), 32'(e.outs[0]));
        chk("out1", 32'(out1), 32'(e.outs[1]));
        chk("out2", 32'(out2), 32'(e.outs[2]));
        chk("out3", 32'(out3), 32'(e.outs[3]));
        if (e.fv) begin
          n_frames++;
          $display("frame %0d: %02h %02h %02h %02h", n_frames, out0, out1, out2, out3);
        end
        if (e.err) $display("sync error observed at %0t", $time);
      end
    end
  end

  initial begin
    int gen_pos;
    logic v, s;
    rst_n    = 1'b0;
    valid_in = 1'b0;
    sync_in  = 1'b0;
    data_in  = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Basic frame, then two back-to-back frames.
    frame(8'h11, 8'h22, 8'h33, 8'h44);
    frame(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    frame(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    beat(1'b0, 1'b0, 8'h00);

    // Gaps between every beat.
    beat(1'b1, 1'b1, 8'h55); beat(1'b0, 1'b0, 8'hEE);
    beat(1'b1, 1'b0, 8'h66); beat(1'b0, 1'b1, 8'hEE);
    beat(1'b1, 1'b0, 8'h77); beat(1'b0, 1'b0, 8'hEE);
    beat(1'b1, 1'b0, 8'h88); beat(1'b0, 1'b0, 8'hEE);

    // Early sync mid-frame.
    beat(1'b1, 1'b1, 8'h01);
    beat(1'b1, 1'b0, 8'h02);
    frame(8'h03, 8'h04, 8'h05, 8'h06);

    // Missing sync after a good frame; sync-less beats ignored until next sync.
    beat(1'b1, 1'b0, 8'h99);
    beat(1'b1, 1'b0, 8'h9A);
    beat(1'b1, 1'b0, 8'h9B);
    frame(8'hC0, 8'hC1, 8'hC2, 8'hC3);

    // Reset after two beats of a frame.
    beat(1'b1, 1'b1, 8'hAA);
    beat(1'b1, 1'b0, 8'hBB);
    @(negedge clk);
    valid_in = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset_state("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    beat(1'b1, 1'b0, 8'hCC);
    beat(1'b1, 1'b0, 8'hDD);
    frame(8'hD0, 8'hD1, 8'hD2, 8'hD3);

    // Randomized traffic with occasional sync faults and idle cycles.
    gen_pos = 0;
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 3) != 0);
      if (gen_pos == 0) s = ($urandom_range(0, 9) != 0);
      else              s = ($urandom_range(0, 19) == 0);
      if (v) gen_pos = (gen_pos + 1) % 4;
      beat(v, s, 8'($urandom));
    end

    repeat (3) beat(1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
